// File: rtl/keystroke_parser.sv
// Calculator keystroke front end: builds two decimal operands and an operator mode from ASCII keys.
// Optional feature macro: KP_BACKSPACE_EN enables Backspace editing of the operand being entered.
module keystroke_parser #(
  parameter int NUM_WIDTH  = 10,
  parameter int MAX_DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           ascii_in,
  input  logic                 ascii_valid,
  output logic [2:0]           mode_select,
  output logic [1:0]           valid_check,
  output logic [NUM_WIDTH-1:0] operand_a,
  output logic [NUM_WIDTH-1:0] operand_b,
  output logic                 print_enable
);

  typedef enum logic [1:0] {OPA = 2'd0, OPB = 2'd1, DONE = 2'd2} stateT;

  localparam int WW = NUM_WIDTH + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [WW-1:0] MAX_VAL = {{4{1'b0}}, {NUM_WIDTH{1'b1}}};

  localparam logic [1:0] V_IDLE = 2'b00;
  localparam logic [1:0] V_OK   = 2'b01;
  localparam logic [1:0] V_BAD  = 2'b10;
  localparam logic [1:0] V_OVF  = 2'b11;

  function automatic logic [2:0] opCode(input logic [7:0] k);
    case (k)
      8'h2B:   return 3'b001;
      8'h2D:   return 3'b010;
      8'h2A:   return 3'b011;
      8'h2F:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [WW-1:0] appendDigit(input logic [NUM_WIDTH-1:0] acc, input logic [3:0] d);
    return WW'(acc) * WW'(10) + WW'(d);
  endfunction

  stateT                stateR, stateN;
  logic [NUM_WIDTH-1:0] aR, aN, bR, bN;
  logic [CW-1:0]        cntAR, cntAN, cntBR, cntBN;
  logic [2:0]           modeR, modeN;
  logic [1:0]           validR, validN;
  logic                 printR, printN;

  logic [NUM_WIDTH-1:0] accCur;
  logic [CW-1:0]        cntCur;
  logic [WW-1:0]        sum;
  logic                 isDigit, digitOk, isEnter, isClear;

  // State register: every output is driven straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR <= OPA;
      aR     <= '0;
      bR     <= '0;
      cntAR  <= '0;
      cntBR  <= '0;
      modeR  <= 3'b000;
      validR <= V_IDLE;
      printR <= 1'b0;
    end else begin
      stateR <= stateN;
      aR     <= aN;
      bR     <= bN;
      cntAR  <= cntAN;
      cntBR  <= cntBN;
      modeR  <= modeN;
      validR <= validN;
      printR <= printN;
    end
  end

  // Next-state and next-data decode of the strobed key.
  always_comb begin
    accCur  = (stateR == OPB) ? bR : aR;
    cntCur  = (stateR == OPB) ? cntBR : cntAR;
    sum     = appendDigit(accCur, ascii_in[3:0]);
    isDigit = (ascii_in >= 8'h30) && (ascii_in <= 8'h39);
    digitOk = (cntCur != CNT_MAX) && (sum <= MAX_VAL);
    isEnter = (ascii_in == 8'h0D) || (ascii_in == 8'h3D);
    isClear = (ascii_in == 8'h1B) || (ascii_in == 8'h63);
    stateN  = stateR;
    aN      = aR;
    bN      = bR;
    cntAN   = cntAR;
    cntBN   = cntBR;
    modeN   = modeR;
    validN  = validR;
    printN  = 1'b0;
    if (ascii_valid) begin
      validN = V_BAD;
      if (isDigit) begin
        if (stateR == DONE) begin
          aN     = NUM_WIDTH'(ascii_in[3:0]);
          bN     = '0;
          cntAN  = CW'(1);
          cntBN  = '0;
          modeN  = 3'b000;
          stateN = OPA;
          validN = V_OK;
        end else if (digitOk) begin
          if (stateR == OPB) begin
            bN    = sum[NUM_WIDTH-1:0];
            cntBN = cntBR + CW'(1);
          end else begin
            aN    = sum[NUM_WIDTH-1:0];
            cntAN = cntAR + CW'(1);
          end
          validN = V_OK;
        end else begin
          validN = V_OVF;
        end
      end else if (opCode(ascii_in) != 3'b000) begin
        if (stateR == OPA && cntAR != '0) begin
          modeN  = opCode(ascii_in);
          stateN = OPB;
          validN = V_OK;
        end else if (stateR == OPB && cntBR == '0) begin
          modeN  = opCode(ascii_in);  // operator correction before any B digit
          validN = V_OK;
        end else begin
          validN = V_BAD;
        end
      end else if (ascii_in == 8'h73) begin
        if (stateR == OPA && cntAR != '0) begin
          modeN  = 3'b101;
          stateN = DONE;
          printN = 1'b1;
          validN = V_OK;
        end else begin
          validN = V_BAD;
        end
      end else if (isEnter) begin
        if (stateR == OPB && cntBR != '0) begin
          stateN = DONE;
          printN = 1'b1;
          validN = V_OK;
        end else begin
          validN = V_BAD;
        end
      end else if (isClear) begin
        stateN = OPA;
        aN     = '0;
        bN     = '0;
        cntAN  = '0;
        cntBN  = '0;
        modeN  = 3'b000;
        validN = V_OK;
`ifdef KP_BACKSPACE_EN
      end else if (ascii_in == 8'h08) begin
        if (stateR != DONE && cntCur != '0) begin
          if (stateR == OPB) begin
            bN    = accCur / NUM_WIDTH'(10);
            cntBN = cntBR - CW'(1);
          end else begin
            aN    = accCur / NUM_WIDTH'(10);
            cntAN = cntAR - CW'(1);
          end
          validN = V_OK;
        end else if (stateR == OPB) begin
          modeN  = 3'b000;
          stateN = OPA;
          validN = V_OK;
        end else begin
          validN = V_BAD;
        end
`endif
      end else begin
        validN = V_BAD;
      end
    end else begin
      validN = validR;
    end
  end

  // Output drive from the registered state.
  always_comb begin
    mode_select  = modeR;
    valid_check  = validR;
    operand_a    = aR;
    operand_b    = bR;
    print_enable = printR;
  end

endmodule

// File: tb/tb_keystroke_parser.sv
// Directed self-checking bench for keystroke_parser (default parameters).
module tb_keystroke_parser;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ascii_in = 8'h00;
  logic       ascii_valid = 1'b0;
  logic [2:0] mode_select;
  logic [1:0] valid_check;
  logic [9:0] operand_a;
  logic [9:0] operand_b;
  logic       print_enable;
  int checks = 0;
  int errors = 0;

  keystroke_parser #(.NUM_WIDTH(10), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .mode_select(mode_select), .valid_check(valid_check),
    .operand_a(operand_a), .operand_b(operand_b), .print_enable(print_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobe one key; returns at the negedge after the capturing posedge.
  task automatic key(input logic [7:0] c);
    @(negedge clk);
    ascii_in = c;
    ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic checkAll(input string tag, input int a, input int b, input int m, input int v, input int p);
    check({tag, ".a"}, 32'(operand_a), 32'(a));
    check({tag, ".b"}, 32'(operand_b), 32'(b));
    check({tag, ".mode"}, 32'(mode_select), 32'(m));
    check({tag, ".valid"}, 32'(valid_check), 32'(v));
    check({tag, ".print"}, 32'(print_enable), 32'(p));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle();
    checkAll("reset", 0, 0, 0, 0, 0);

    key("3"); key("6"); key("s");
    checkAll("square", 36, 0, 5, 1, 1);
    idle();
    check("square.pulse_end", 32'(print_enable), 32'd0);

    key("1");
    checkAll("done_digit", 1, 0, 0, 1, 0);
    key("2"); key("+"); key("7"); key(8'h0D);
    checkAll("add", 12, 7, 1, 1, 1);
    idle();
    check("add.pulse_end", 32'(print_enable), 32'd0);
    key("+");
    check("done_op_invalid", 32'(valid_check), 32'd2);

    key(8'h1B);
    checkAll("escape", 0, 0, 0, 1, 0);
    key("1"); key("0"); key("2"); key("4");
    checkAll("a_digits_limit", 102, 0, 0, 3, 0);

    key("c");
    checkAll("clear_c", 0, 0, 0, 1, 0);
    key("9"); key("9"); key("9"); key("+");
    key("1"); key("0"); key("2"); key("4");
    checkAll("b_digits_limit", 999, 102, 1, 3, 0);

    key(8'h1B);
    key("5"); key("+"); key("*");
    check("correction.mode", 32'(mode_select), 32'd3);
    key("2"); key("=");
    checkAll("mul", 5, 2, 3, 1, 1);
    key("x");
    checkAll("bad_key", 5, 2, 3, 2, 0);
    repeat (3) idle();
    check("valid_hold", 32'(valid_check), 32'd2);

    key(8'h1B); key(8'h0D);
    checkAll("enter_in_opa", 0, 0, 0, 2, 0);
    key("s");
    check("s_empty_a", 32'(valid_check), 32'd2);

`ifdef KP_BACKSPACE_EN
    key(8'h1B);
    key("4"); key("7"); key(8'h08);
    check("bs_a", 32'(operand_a), 32'd4);
    key("3");
    checkAll("bs_edit", 43, 0, 0, 1, 0);
    key(8'h1B);
    key("8"); key("-"); key(8'h08);
    checkAll("bs_mode_clear", 8, 0, 0, 1, 0);
    key("+");
    checkAll("bs_reop", 8, 0, 1, 1, 0);
`else
    key(8'h1B);
    key("4"); key(8'h08);
    checkAll("bs_disabled", 4, 0, 0, 2, 0);
`endif

    key(8'h1B);
    key("6");
    @(negedge clk);
    ascii_in = "+";
    ascii_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    rst = 1'b0;
    checkAll("rst_wins", 0, 0, 0, 0, 0);
    key("+");
    check("rst_state_opa", 32'(valid_check), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
